seg7_msg_scroller: RTL and testbench

//  Core display stage that feeds the 8-bit io_out bus of the chip top.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/seg7_msg_scroller.sv | 119 +++++++++++
 tb/tb_seg7_msg_scroller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment message scroller: FSM encodings,
// the hex-to-segment table and display constants.
package seg7_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int         DP_BIT    = 7;

  // Segment patterns in gfedcba order, indexed by the hex digit value.
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex7(input logic [3:0] digit);
    return HEX7_TABLE[digit];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex digit to active-high 7-segment pattern (gfedcba).
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segs
);

  assign o_segs = hex7(i_nibble);

endmodule

// File: rtl/seg7_msg_scroller.sv
// Scrolls a fixed hex message on a 7-segment display: each digit is shown for
// one tick period, followed by a blank period; dp marks the last digit.
module seg7_msg_scroller
  import seg7_pkg::*;
#(
  parameter int                     PRESCALE = 4,
  parameter int                     MSG_LEN  = 3,
  parameter logic [4*MSG_LEN-1:0]   MESSAGE  = 12'h1A0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] seg_out,
  output logic       msg_wrap
);

  localparam int             PW         = $clog2(PRESCALE);
  localparam int             IW         = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]  IDX_LAST   = IW'(MSG_LEN - 1);

  logic [PW-1:0] r_presc;
  logic          w_tick;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic          r_wrap_pend;
  logic          w_wrap_nxt;

  logic [3:0]    w_nibble;
  logic [6:0]    w_segs;
  logic [7:0]    w_disp;

  assign w_tick = en && (r_presc == PRESC_LAST);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  // NOTE: every signal of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wrap_nxt  = 1'b0;
    case (r_state)
      ST_SHOW: begin
        if (w_tick) w_state_nxt = ST_BLANK;
      end
      ST_BLANK: begin
        if (w_tick) begin
          w_state_nxt = ST_SHOW;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt  = '0;
            w_wrap_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
      default: w_state_nxt = ST_SHOW;
    endcase
  end

  // The wrap flag rides alongside the state so the pulse lands on the same
  // edge that the output register first shows digit 0 again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_SHOW;
      r_idx       <= '0;
      r_wrap_pend <= 1'b0;
    end else if (en) begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_wrap_pend <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_nibble = '0;
    for (int k = 0; k < MSG_LEN; k++) begin
      if (r_idx == IW'(k)) w_nibble = MESSAGE[4*(MSG_LEN-1-k) +: 4];
    end
  end

  seg7_hex_decoder u_dec (
    .i_nibble (w_nibble),
    .o_segs   (w_segs)
  );

  always_comb begin
    w_disp = SEG_BLANK;
    if (r_state == ST_SHOW) begin
      w_disp[6:0]    = w_segs;
      w_disp[DP_BIT] = (r_idx == IDX_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_out  <= SEG_BLANK;
      msg_wrap <= 1'b0;
    end else if (en) begin
      seg_out  <= w_disp;
      msg_wrap <= r_wrap_pend;
    end else begin
      msg_wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_msg_scroller.sv
// Bench for seg7_msg_scroller: four configurations run in lockstep against a
// slot-arithmetic model, plus directed literal expectations.
module tb_seg7_msg_scroller;

  localparam int NI  = 4;
  localparam int PRE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  logic [NI-1:0][7:0] seg;
  logic [NI-1:0]      wrap;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  int          len_cfg [NI] = '{3, 1, 8, 8};
  logic [31:0] msg_cfg [NI] = '{32'h1A0, 32'hF, 32'h01234567, 32'h89ABCDEF};
  logic [6:0]  hex_ref [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  seg7_msg_scroller #(.PRESCALE(PRE), .MSG_LEN(3), .MESSAGE(12'h1A0)) u_main (
    .clk(clk), .rst(rst), .en(en), .seg_out(seg[0]), .msg_wrap(wrap[0]));
  seg7_msg_scroller #(.PRESCALE(PRE), .MSG_LEN(1), .MESSAGE(4'hF)) u_one (
    .clk(clk), .rst(rst), .en(en), .seg_out(seg[1]), .msg_wrap(wrap[1]));
  seg7_msg_scroller #(.PRESCALE(PRE), .MSG_LEN(8), .MESSAGE(32'h01234567)) u_sw0 (
    .clk(clk), .rst(rst), .en(en), .seg_out(seg[2]), .msg_wrap(wrap[2]));
  seg7_msg_scroller #(.PRESCALE(PRE), .MSG_LEN(8), .MESSAGE(32'h89ABCDEF)) u_sw1 (
    .clk(clk), .rst(rst), .en(en), .seg_out(seg[3]), .msg_wrap(wrap[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Enabled edge k (k>=1 since reset) falls in display slot ((k-1)/PRE) mod 2*len:
  // even slots show digit slot/2, odd slots are blank.
  function automatic logic [7:0] model_seg(input int i, input int k);
    int p, slot, d;
    logic [3:0] nib;
    p    = (k - 1) / PRE;
    slot = p % (2 * len_cfg[i]);
    if (slot % 2 == 1) return 8'h00;
    d   = slot / 2;
    nib = 4'((msg_cfg[i] >> (4 * (len_cfg[i] - 1 - d))) & 32'hF);
    return {(d == len_cfg[i] - 1), hex_ref[nib]};
  endfunction

  function automatic logic model_wrap(input int i, input int k);
    int p, slot;
    p    = (k - 1) / PRE;
    slot = p % (2 * len_cfg[i]);
    return ((k - 1) % PRE == 0) && (p > 0) && (slot == 0);
  endfunction

  int         n_en = 0;
  logic [7:0] exp_seg  [NI];
  logic       exp_wrap [NI];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_en <= 0;
      for (int i = 0; i < NI; i++) begin
        exp_seg[i]  <= 8'h00;
        exp_wrap[i] <= 1'b0;
      end
    end else if (en) begin
      n_en <= n_en + 1;
      for (int i = 0; i < NI; i++) begin
        exp_seg[i]  <= model_seg(i, n_en + 1);
        exp_wrap[i] <= model_wrap(i, n_en + 1);
      end
    end else begin
      for (int i = 0; i < NI; i++) exp_wrap[i] <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("model_seg[%0d]", i), 32'(seg[i]), 32'(exp_seg[i]));
        check($sformatf("model_wrap[%0d]", i), 32'(wrap[i]), 32'(exp_wrap[i]));
      end
    end
  end

  initial begin
    int wraps;
    int cnt;
    bit found;

    en  = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_seg[%0d]", i), 32'(seg[i]), 32'h00);
      check($sformatf("reset_wrap[%0d]", i), 32'(wrap[i]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;

    wraps = 0;
    for (int e = 1; e <= 105; e++) begin
      @(posedge clk);
      #1;
      if (wrap[0]) wraps++;
      case (e)
        1: begin
          check("e1_main", 32'(seg[0]), 32'h06);
          check("e1_main_wrap", 32'(wrap[0]), 32'h0);
          check("e1_one", 32'(seg[1]), 32'hF1);
          check("e1_one_wrap", 32'(wrap[1]), 32'h0);
          check("e1_sw0", 32'(seg[2]), 32'h3F);
          check("e1_sw1", 32'(seg[3]), 32'h7F);
        end
        5:  begin
          check("e5_main", 32'(seg[0]), 32'h00);
          check("e5_one", 32'(seg[1]), 32'h00);
        end
        9:  begin
          check("e9_main", 32'(seg[0]), 32'h77);
          check("e9_one", 32'(seg[1]), 32'hF1);
          check("e9_one_wrap", 32'(wrap[1]), 32'h1);
        end
        13: check("e13_main", 32'(seg[0]), 32'h00);
        17: check("e17_main", 32'(seg[0]), 32'hBF);
        21: check("e21_main", 32'(seg[0]), 32'h00);
        24: check("e24_main_wrap", 32'(wrap[0]), 32'h0);
        25: begin
          check("e25_main", 32'(seg[0]), 32'h06);
          check("e25_main_wrap", 32'(wrap[0]), 32'h1);
        end
        26: check("e26_main_wrap", 32'(wrap[0]), 32'h0);
        49: check("e49_main_wrap", 32'(wrap[0]), 32'h1);
        57: begin
          check("e57_sw0_dp", 32'(seg[2]), 32'h87);
          check("e57_sw1_dp", 32'(seg[3]), 32'hF1);
        end
        default: ;
      endcase
    end
    check("wrap_count_105", 32'(wraps), 32'd4);
    check("e105_main", 32'(seg[0]), 32'h77);

    // Freeze while showing 'A'.
    @(negedge clk);
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("freeze_seg", 32'(seg[0]), 32'h77);
    check("freeze_wrap", 32'(wrap[0]), 32'h0);
    @(negedge clk);
    en = 1'b1;
    cnt = 0;
    found = 1'b0;
    for (int e = 0; e < 20 && !found; e++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (seg[0] == 8'h00) found = 1'b1;
    end
    check("resume_edges_to_blank", 32'(cnt), 32'd4);

    // Asynchronous reset in the middle of a blank period.
    #3;
    rst = 1'b0;
    #1;
    check("async_blank_seg", 32'(seg[0]), 32'h00);
    check("async_blank_wrap", 32'(wrap[0]), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("restart_seg", 32'(seg[0]), 32'h06);
    check("restart_wrap", 32'(wrap[0]), 32'h0);

    // Asynchronous reset while the wrap pulse is high.
    found = 1'b0;
    for (int e = 0; e < 40 && !found; e++) begin
      @(posedge clk);
      #1;
      if (wrap[0]) found = 1'b1;
    end
    check("wrap_seen", 32'(found), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check("async_wrap_clr", 32'(wrap[0]), 32'h0);
    check("async_seg_clr", 32'(seg[0]), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
